gameplay_datapath: RTL and testbench

//  Datapath slave of the gameplay FSM. Holds the moving block's x/y position and direction.

---
 rtl/gameplay_datapath.sv | 89 ++++++++
 tb/tb_gameplay_datapath.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gameplay_datapath.sv
// gameplay_datapath: block position/direction, prev row x, score and chances with FSM status flags
module gameplay_datapath #(
  parameter int STEP_DIV     = 833333,
  parameter int X_MAX        = 144,
  parameter int BLOCK_W      = 16,
  parameter int CHANCES_INIT = 10,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               ld_x,
  input  logic               ld_y,
  input  logic               ld_d,
  input  logic               enable,
  input  logic               save_x,
  input  logic               inc_score,
  input  logic               dec_chances,
  input  logic               new_direction,
  input  logic [7:0]         new_x_position,
  input  logic [6:0]         new_y_position,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         chances,
  output logic               c,
  output logic               o
);
  localparam int TW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [7:0] XM = 8'(X_MAX);
  logic dir, dir_step, prev_valid, last;
  logic [7:0] prev_x, xe, x_step;
  logic [TW-1:0] tick;
  logic [8:0] diff;
  assign last = tick == TW'(STEP_DIV - 1);
  assign xe = x > XM ? XM : x;
  // next position/direction for one step, out-of-range x clamped to the right edge first
  always_comb begin
    x_step = dir ? (xe < XM ? xe + 8'd1 : XM - 8'd1) : (xe != 8'd0 ? xe - 8'd1 : 8'd1);
    dir_step = dir ? xe < XM : xe == 8'd0;
  end
  // position, direction and step divider; loads restart the divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      dir <= 1'b1;
      tick <= '0;
    end else begin
      if (ld_x) x <= new_x_position;
      if (ld_d) dir <= new_direction;
      if (ld_x | ld_d) tick <= '0;
      else if (enable) begin
        tick <= last ? '0 : tick + TW'(1);
        if (last) begin
          x <= x_step;
          dir <= dir_step;
        end
      end
    end
  end
  // row position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) y <= '0;
    else if (ld_y) y <= new_y_position;
  end
  // game bookkeeping; new_game wins over per-row updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score <= '0;
      chances <= 4'(CHANCES_INIT);
      prev_x <= '0;
      prev_valid <= 1'b0;
    end else if (new_game) begin
      score <= '0;
      chances <= 4'(CHANCES_INIT);
      prev_valid <= 1'b0;
    end else begin
      if (inc_score && score != '1) score <= score + SCORE_W'(1);
      if (dec_chances && chances != '0) chances <= chances - 4'd1;
      if (save_x) begin
        prev_x <= x;
        prev_valid <= 1'b1;
      end
    end
  end
  assign diff = x >= prev_x ? {1'b0, x} - {1'b0, prev_x} : {1'b0, prev_x} - {1'b0, x};
  assign o = !prev_valid | (diff < 9'(BLOCK_W));
  assign c = chances != '0;
endmodule

// File: tb/tb_gameplay_datapath.sv
// tb_gameplay_datapath: vector table, corner sequences and randomized model check of gameplay_datapath
module tb_gameplay_datapath;
  localparam int SD = 2, XMAX = 144, BW = 16, CI = 3;
  logic clk = 0, reset = 1;
  logic new_game = 0, ld_x = 0, ld_y = 0, ld_d = 0, enable = 0, save_x = 0;
  logic inc_score = 0, dec_chances = 0, new_direction = 0;
  logic [7:0] new_x_position = 0;
  logic [6:0] new_y_position = 0;
  logic [7:0] x;
  logic [6:0] y;
  logic [3:0] score, chances;
  logic c, o;
  int checks = 0, failures = 0;

  typedef struct { bit ng, lx, ly, ld, en, sx, inc, dec, nd; int nx, ny; } vin_t;
  typedef struct { vin_t i; int ex, ey, esc, ech, eo; } vec_t;
  vec_t tbl[$];

  int mx, my, mdir, mprev, mpv, msc, mch, mph;

  gameplay_datapath #(.STEP_DIV(SD), .X_MAX(XMAX), .BLOCK_W(BW), .CHANCES_INIT(CI), .SCORE_W(4)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .ld_x(ld_x), .ld_y(ld_y), .ld_d(ld_d),
    .enable(enable), .save_x(save_x), .inc_score(inc_score), .dec_chances(dec_chances),
    .new_direction(new_direction), .new_x_position(new_x_position), .new_y_position(new_y_position),
    .x(x), .y(y), .score(score), .chances(chances), .c(c), .o(o));

  always #5 clk = ~clk;

  function automatic vin_t mk(bit ng, bit lx, bit ly, bit ld, bit en, bit sx, bit inc, bit dec, bit nd, int nx, int ny);
    vin_t v;
    v.ng = ng; v.lx = lx; v.ly = ly; v.ld = ld; v.en = en; v.sx = sx;
    v.inc = inc; v.dec = dec; v.nd = nd; v.nx = nx; v.ny = ny;
    return v;
  endfunction

  task automatic add(vin_t v, int ex, int ey, int esc, int ech, int eo);
    vec_t r;
    r.i = v; r.ex = ex; r.ey = ey; r.esc = esc; r.ech = ech; r.eo = eo;
    tbl.push_back(r);
  endtask

  task automatic apply(vin_t v);
    new_game = v.ng; ld_x = v.lx; ld_y = v.ly; ld_d = v.ld; enable = v.en; save_x = v.sx;
    inc_score = v.inc; dec_chances = v.dec; new_direction = v.nd;
    new_x_position = 8'(v.nx); new_y_position = 7'(v.ny);
  endtask

  task automatic chk(string tag, string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s %s: got %0d expected %0d", tag, nm, act, exp);
    end
  endtask

  task automatic check_out(string tag, int ex, int ey, int esc, int ech, int eo);
    chk(tag, "x", int'(x), ex);
    chk(tag, "y", int'(y), ey);
    chk(tag, "score", int'(score), esc);
    chk(tag, "chances", int'(chances), ech);
    chk(tag, "c", int'(c), ech != 0 ? 1 : 0);
    chk(tag, "o", int'(o), eo);
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mdir = 1; mprev = 0; mpv = 0; msc = 0; mch = CI; mph = 0;
  endtask

  task automatic model_cycle(vin_t v);
    int nx_, nd_, p;
    nx_ = mx; nd_ = mdir;
    if (v.lx || v.ld) begin
      mph = 0;
      if (v.lx) nx_ = v.nx;
      if (v.ld) nd_ = v.nd;
    end else if (v.en) begin
      mph++;
      if (mph == SD) begin
        mph = 0;
        p = mx > XMAX ? XMAX : mx;
        if (mdir != 0) begin
          if (p < XMAX) nx_ = p + 1;
          else begin nx_ = XMAX - 1; nd_ = 0; end
        end else begin
          if (p > 0) nx_ = p - 1;
          else begin nx_ = 1; nd_ = 1; end
        end
      end
    end
    if (v.ly) my = v.ny;
    if (v.ng) begin
      msc = 0; mch = CI; mpv = 0;
    end else begin
      if (v.inc && msc < 15) msc++;
      if (v.dec && mch > 0) mch--;
      if (v.sx) begin mprev = mx; mpv = 1; end
    end
    mx = nx_; mdir = nd_;
  endtask

  function automatic int model_o();
    int d;
    d = mx > mprev ? mx - mprev : mprev - mx;
    return (mpv == 0 || d < BW) ? 1 : 0;
  endfunction

  initial begin
    vin_t idle, en1, v;
    int s1[6] = '{143, 144, 144, 143, 143, 142};
    int s2[4] = '{1, 0, 0, 1};
    idle = mk(0,0,0,0,0,0,0,0,0,0,0);
    en1 = mk(0,0,0,0,1,0,0,0,0,0,0);
    add(idle, 0, 0, 0, 3, 1);
    add(mk(0,1,1,1,0,0,0,0,1,0,50), 0, 50, 0, 3, 1);
    for (int k = 1; k <= 10; k++) add(en1, k / 2, 50, 0, 3, 1);
    for (int k = 0; k < 6; k++) add(idle, 5, 50, 0, 3, 1);
    add(mk(0,1,0,1,0,0,0,0,1,143,0), 143, 50, 0, 3, 1);
    for (int k = 0; k < 6; k++) add(en1, s1[k], 50, 0, 3, 1);
    add(mk(0,1,0,1,0,0,0,0,0,1,0), 1, 50, 0, 3, 1);
    for (int k = 0; k < 4; k++) add(en1, s2[k], 50, 0, 3, 1);
    add(mk(0,1,0,0,0,0,0,0,0,40,0), 40, 50, 0, 3, 1);
    add(mk(0,1,0,0,0,1,0,0,0,144,0), 144, 50, 0, 3, 0);
    add(mk(0,1,0,0,0,0,0,0,0,55,0), 55, 50, 0, 3, 1);
    add(mk(0,1,0,0,0,0,0,0,0,56,0), 56, 50, 0, 3, 0);
    add(mk(0,1,0,0,0,0,0,0,0,25,0), 25, 50, 0, 3, 1);
    add(mk(0,1,0,0,0,0,0,0,0,24,0), 24, 50, 0, 3, 0);
    for (int k = 1; k <= 4; k++) add(mk(0,0,0,0,0,0,0,1,0,0,0), 24, 50, 0, 3 - k < 0 ? 0 : 3 - k, 0);
    for (int k = 1; k <= 20; k++) add(mk(0,0,0,0,0,0,1,0,0,0,0), 24, 50, k > 15 ? 15 : k, 0, 0);
    add(mk(1,0,0,0,0,0,1,0,0,0,0), 24, 50, 0, 3, 1);
    add(en1, 24, 50, 0, 3, 1);
    add(mk(0,1,0,0,1,0,0,0,0,100,0), 100, 50, 0, 3, 1);
    add(en1, 100, 50, 0, 3, 1);
    add(en1, 101, 50, 0, 3, 1);

    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    foreach (tbl[i]) begin
      @(negedge clk) apply(tbl[i].i);
      @(posedge clk) #1;
      check_out($sformatf("row%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].esc, tbl[i].ech, tbl[i].eo);
    end

    @(negedge clk) apply(mk(0,0,0,0,1,0,0,1,0,0,0));
    @(posedge clk) #1;
    check_out("pre_reset", 101, 50, 0, 2, 1);
    @(negedge clk) apply(idle);
    #2 reset = 1;
    #1 check_out("async_reset", 0, 0, 0, 3, 1);
    @(negedge clk) begin reset = 0; apply(en1); end
    @(posedge clk) #1;
    check_out("post_reset1", 0, 0, 0, 3, 1);
    @(posedge clk) #1;
    check_out("post_reset2", 1, 0, 0, 3, 1);

    @(negedge clk) apply(idle);
    reset = 1;
    #2 reset = 0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      v = mk($urandom % 40 == 0, $urandom % 12 == 0, $urandom % 10 == 0, $urandom % 15 == 0,
             $urandom % 4 != 0, $urandom % 8 == 0, $urandom % 3 == 0, $urandom % 5 == 0,
             $urandom % 2 == 1, int'($urandom % 256), int'($urandom % 128));
      @(negedge clk) apply(v);
      model_cycle(v);
      @(posedge clk) #1;
      check_out($sformatf("rand%0d", n), mx, my, msc, mch, model_o());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
